// File: rtl/grf_scoreboard.sv
// Register file with two combinational read ports, one write port, optional write bypass and per-register pending bits.
// Optional GRF_TRACE_EN: prints a trace line for every accepted write.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       pc_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic              rd_busy1_o,
  output logic              rd_busy2_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic [ADDR_W:0]   busy_cnt_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;
  logic                         wr_ok, iss_ok, cnt_inc, cnt_dec;

  assign wr_ok  = wr_en_i && (wr_addr_i != '0);
  assign iss_ok = issue_en_i && (issue_addr_i != '0);

  logic [1:0][ADDR_W-1:0] ra;
  logic [DATA_W-1:0]      rdat [2];
  logic [1:0]             rbusy;
  assign ra = {rd_addr2_i, rd_addr1_i};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit;
    assign hit      = (BYPASS != 0) && wr_ok && (wr_addr_i == ra[p]);
    assign rdat[p]  = (ra[p] == '0) ? '0 : hit ? wr_data_i : regs_q[ra[p]];
    // A bypass hit means the value is arriving now, so the consumer need not stall.
    assign rbusy[p] = busy_q[ra[p]] && (ra[p] != '0) && !hit;
  end

  assign rd_data1_o = rdat[0];
  assign rd_data2_o = rdat[1];
  assign rd_busy1_o = rbusy[0];
  assign rd_busy2_o = rbusy[1];
  assign busy_cnt_o = busy_cnt_q;

  // Issue is applied after the clear so a new producer to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr_i]    = 1'b0;
    if (iss_ok) busy_d[issue_addr_i] = 1'b1;
  end

  assign cnt_inc = iss_ok && !busy_q[issue_addr_i];
  assign cnt_dec = wr_ok && busy_q[wr_addr_i] && !(iss_ok && (issue_addr_i == wr_addr_i));
  assign busy_cnt_d = busy_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr_i] <= wr_data_i;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_ok)
      $display("@%08h: $%2d <= %h", pc_i, wr_addr_i, wr_data_i);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
`endif
endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed table, hand sequences, and randomized run against a reference model.
module tb_grf_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [4:0]  ra1, ra2, wa, ia;
  logic        we, ie;
  logic [31:0] wd;
  logic [31:0] d1, d2, n1, n2;
  logic        b1, b2, nb1, nb2;
  logic [5:0]  cnt, ncnt;

  int pass = 0, total = 0;

  always #5 clk = ~clk;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk_i(clk), .reset_i(reset), .pc_i(pc),
    .rd_addr1_i(ra1), .rd_addr2_i(ra2),
    .rd_data1_o(d1), .rd_data2_o(d2), .rd_busy1_o(b1), .rd_busy2_o(b2),
    .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
    .issue_en_i(ie), .issue_addr_i(ia), .busy_cnt_o(cnt));

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk_i(clk), .reset_i(reset), .pc_i(pc),
    .rd_addr1_i(ra1), .rd_addr2_i(ra2),
    .rd_data1_o(n1), .rd_data2_o(n2), .rd_busy1_o(nb1), .rd_busy2_o(nb2),
    .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
    .issue_en_i(ie), .issue_addr_i(ia), .busy_cnt_o(ncnt));

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic ie; logic [4:0] ia;
    logic [4:0] ra1, ra2;
    logic [31:0] d1; logic b1; logic [31:0] d2; logic b2; logic [5:0] cnt;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic i, logic [4:0] ad,
                              logic [4:0] r1, logic [4:0] r2, logic [31:0] e1, logic eb1,
                              logic [31:0] e2, logic eb2, logic [5:0] ec);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.ie = i; v.ia = ad; v.ra1 = r1; v.ra2 = r2;
    v.d1 = e1; v.b1 = eb1; v.d2 = e2; v.b2 = eb2; v.cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic i, input logic [4:0] ad, input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; ie = i; ia = ad; ra1 = r1; ra2 = r2;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pc = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    reset = 1'b0;

    // Reset state over every address
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); #1;
      chk($sformatf("rst_d1[%0d]", a), d1, 0);
      chk($sformatf("rst_b1[%0d]", a), b1, 0);
      chk($sformatf("rst_d2[%0d]", 31 - a), d2, 0);
      chk($sformatf("rst_b2[%0d]", 31 - a), b2, 0);
    end
    chk("rst_cnt", cnt, 0);

    tbl[0]  = mk(0, 0, 0,            1, 5, 5, 0, 0,            0, 0,            0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 5, 5, 0,            1, 0,            1, 1);
    tbl[2]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 6, 32'hDEADBEEF, 0, 0,            0, 1);
    tbl[3]  = mk(0, 0, 0,            0, 0, 5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(1, 0, 32'h12345678, 1, 0, 0, 5, 0,            0, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0, 0, 0,            0, 0,            0, 0);
    tbl[6]  = mk(0, 0, 0,            1, 7, 7, 5, 0,            0, 32'hDEADBEEF, 0, 0);
    tbl[7]  = mk(1, 7, 32'h1,        1, 7, 7, 7, 32'h1,        0, 32'h1,        0, 1);
    tbl[8]  = mk(0, 0, 0,            0, 0, 7, 5, 32'h1,        1, 32'hDEADBEEF, 0, 1);
    tbl[9]  = mk(1, 7, 32'h2,        0, 0, 7, 7, 32'h2,        0, 32'h2,        0, 1);
    tbl[10] = mk(0, 0, 0,            0, 0, 7, 5, 32'h2,        0, 32'hDEADBEEF, 0, 0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].ra1, tbl[i].ra2);
      @(negedge clk);
      chk($sformatf("tbl%0d_d1", i), d1, tbl[i].d1);
      chk($sformatf("tbl%0d_b1", i), b1, tbl[i].b1);
      chk($sformatf("tbl%0d_d2", i), d2, tbl[i].d2);
      chk($sformatf("tbl%0d_b2", i), b2, tbl[i].b2);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
      tick;
    end

    // Three producers pending, then a reset that also carries a write and an issue
    drive(1, 3, 32'h55, 1, 3, 0, 0); tick;
    drive(0, 0, 0, 1, 4, 0, 0); tick;
    drive(0, 0, 0, 1, 6, 3, 4);
    @(negedge clk);
    chk("seq_cnt2", cnt, 2);
    tick;
    drive(0, 0, 0, 0, 0, 3, 6);
    @(negedge clk);
    chk("seq_cnt3", cnt, 3);
    chk("seq_d3", d1, 32'h55);
    chk("seq_b3", b1, 1);
    chk("seq_b6", b2, 1);
    reset = 1'b1;
    drive(1, 3, 32'h99, 1, 5, 3, 6);
    tick;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 3, 5);
    @(negedge clk);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_d3", d1, 0);
    chk("mrst_b3", b1, 0);
    chk("mrst_d5", d2, 0);
    chk("mrst_b5", b2, 0);
    ra1 = 4; ra2 = 6; #1;
    chk("mrst_b4", b1, 0);
    chk("mrst_b6", b2, 0);
    tick;

    // No-bypass instance returns the stored value during the write cycle
    pc = 32'h0000_3000;
    drive(1, 9, 32'hA5A5A5A5, 0, 0, 9, 9);
    @(negedge clk);
    chk("nb_old", n1, 0);
    chk("bp_new", d1, 32'hA5A5A5A5);
    tick;
    drive(0, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    chk("nb_next", n1, 32'hA5A5A5A5);
    tick;

    // Randomized run against the reference model
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0); tick; reset = 1'b0;
    for (int a = 0; a < 32; a++) begin m_regs[a] = '0; m_busy[a] = 1'b0; end
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] r[2];
      logic [31:0] ed, en;
      logic hit;
      int pop;
      reset = ($urandom_range(0, 63) == 0);
      we  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ia  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      pc  = $urandom;
      @(negedge clk);
      r[0] = ra1; r[1] = ra2;
      for (int p = 0; p < 2; p++) begin
        hit = we && (wa != 0) && (wa == r[p]);
        en  = (r[p] == 0) ? 32'h0 : m_regs[r[p]];
        ed  = hit ? wd : en;
        chk($sformatf("rnd%0d_d%0d", n, p + 1), (p == 0) ? d1 : d2, ed);
        chk($sformatf("rnd%0d_b%0d", n, p + 1), (p == 0) ? b1 : b2, m_busy[r[p]] && (r[p] != 0) && !hit);
        chk($sformatf("rnd%0d_nd%0d", n, p + 1), (p == 0) ? n1 : n2, en);
        chk($sformatf("rnd%0d_nb%0d", n, p + 1), (p == 0) ? nb1 : nb2, m_busy[r[p]] && (r[p] != 0));
      end
      pop = 0;
      for (int a = 0; a < 32; a++) pop += int'(m_busy[a]);
      chk($sformatf("rnd%0d_cnt", n), cnt, 6'(pop));
      chk($sformatf("rnd%0d_ncnt", n), ncnt, 6'(pop));
      @(posedge clk);
      if (reset) begin
        for (int a = 0; a < 32; a++) begin m_regs[a] = '0; m_busy[a] = 1'b0; end
      end else begin
        if (we && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
        if (ie && ia != 0) m_busy[ia] = 1'b1;
      end
      #1;
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU core. Successor to the single-cycle GRF.
- Two combinational read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register pending (scoreboard) bits: set when a producer instruction issues, cleared on writeback, so hazard logic can stall on unresolved sources.
- Sits between decode/issue (reads, issue marks) and writeback (writes).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W; register 0 is hardwired zero.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  PC of the writing instruction (trace only).
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- rd_busy1  output  1  register at rd_addr1 has a pending producer.
- rd_busy2  output  1  register at rd_addr2 has a pending producer.
- wr_en  input  1  writeback enable.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback data.
- issue_en  input  1  a producer instruction issues this cycle.
- issue_addr  input  ADDR_W  destination of the issuing producer.
- busy_cnt  output  ADDR_W+1  number of registers currently pending.

Behaviour:
Reset
- On a posedge with reset=1: all registers = 0, all busy bits = 0, busy_cnt = 0.
- Reset overrides wr_en/issue_en in the same cycle. Mid-operation reset discards all pending state.

Storage and writes
- regs[0..2**ADDR_W-1] of DATA_W bits.
- Write at posedge when wr_en=1 and wr_addr!=0; visible through storage from the next cycle.
- Writes to address 0 are ignored. Register 0 always reads 0 and is never busy.

Reads (combinational, zero latency)
- rd_dataN = 0 if rd_addrN==0.
- Else, if BYPASS=1 and wr_en=1 and wr_addr==rd_addrN: rd_dataN = wr_data.
- Else rd_dataN = regs[rd_addrN].

Busy reads
- rd_busyN = busy[rd_addrN] & (rd_addrN!=0).
- When BYPASS=1, rd_busyN is also masked to 0 on a same-cycle bypass hit, since the data is already available.

Scoreboard update at posedge (no reset)
- write clear: wr_en && wr_addr!=0 → busy[wr_addr] <= 0.
- issue set: issue_en && issue_addr!=0 → busy[issue_addr] <= 1.
- Same address for both: issue wins; busy stays/becomes 1 for the new producer.
- Different addresses: both updates apply.
- Issue to an already-busy register: it stays busy (WAW); no error.
- Write to a non-busy register: the data write still happens; busy stays 0.

busy_cnt
- Registered; equals the popcount of the busy bits after each update.
- Changes by -1, 0 or +1 per cycle, computed incrementally from the set/clear events above.
- Range 0..2**ADDR_W-1; no overflow, because register 0 is excluded.

Optional Feature:
- GRF_TRACE_EN defined: on every accepted write (wr_en, wr_addr!=0, reset=0), simulation prints "@<pc hex 8>: $<wr_addr decimal 2> <= <wr_data hex>" at the clock edge.
- Undefined: no display statements compiled, and pc is unused (left unconnected internally). Functional behaviour is identical either way.

Test Plan:
1. Reset, then read all addresses → all rd_data = 0, rd_busy = 0, busy_cnt = 0.
2. Issue addr 5; next cycle read 5 → rd_busy1 = 1, busy_cnt = 1. Then write 5 ← 0xDEADBEEF → same cycle: rd_data1 = 0xDEADBEEF and rd_busy1 = 0 (BYPASS=1). Next cycle: busy_cnt = 0, stored value 0xDEADBEEF.
3. Write addr 0 ← 0x12345678 with issue_en on addr 0 → rd_data = 0, rd_busy = 0, busy_cnt unchanged, no trace line.
4. Addr 7 busy; same cycle issue 7 and write 7 ← 0x1 → after edge busy[7] = 1, regs[7] = 0x1, busy_cnt unchanged.
5. Issue 3, 4, 6 over three cycles (busy_cnt = 3), then assert reset mid-sequence with wr_en on 3 → after edge all busy = 0, busy_cnt = 0, regs[3] = 0.
6. BYPASS=0 build: write 9 ← 0xA5A5A5A5 while reading 9 → old value (0) that cycle, 0xA5A5A5A5 next cycle. With GRF_TRACE_EN and pc = 0x00003000 → prints "@00003000: $ 9 <= a5a5a5a5".
